calculator_chip: RTL and testbench



---
 rtl/calc_pkg.sv | 32 +++
 rtl/calc_alu_if.sv | 21 ++
 rtl/calc_alu.sv | 104 ++++++++++
 rtl/calculator_chip.sv | 94 +++++++++
 tb/tb_calculator_chip.sv | 133 +++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator tile: datapath width, opcode
// encoding, status-flag bit positions on uio_out and the pad direction mask.
package calc_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_OR  = 4'h2,
        OP_AND = 4'h3,
        OP_XOR = 4'h4,
        OP_SHL = 4'h5,
        OP_SHR = 4'h6,
        OP_SAR = 4'h7,
        OP_NEG = 4'h8,
        OP_INV = 4'h9,
        OP_REV = 4'hA,
        OP_ROL = 4'hB,
        OP_ROR = 4'hC,
        OP_LT  = 4'hD,
        OP_GT  = 4'hE,
        OP_EQ  = 4'hF
    } calc_op_e;

    localparam int FLAG_C = 7;
    localparam int FLAG_Z = 6;
    localparam int FLAG_T = 5;

    localparam logic [7:0] UIO_OE_VAL = 8'hE0;

endpackage

// File: rtl/calc_alu_if.sv
// Bundle between the accumulator registers and the combinational ALU.
// master = register side (supplies operands), slave = ALU (returns results).
interface calc_alu_if;
    import calc_pkg::*;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    calc_op_e         op;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             cmp;
    logic             writes_acc;
    logic             writes_cmp;

    modport master (output a, b, op,
                    input  result, carry, zero, cmp, writes_acc, writes_cmp);
    modport slave  (input  a, b, op,
                    output result, carry, zero, cmp, writes_acc, writes_cmp);

endinterface

// File: rtl/calc_alu.sv
// Combinational ALU for the calculator. Ops 0-A (and B/C when
// CALC_ROTATE_EN is defined) produce a new accumulator value; ops D-F only
// produce the compare result. Any other opcode is a no-op.
module calc_alu
    import calc_pkg::*;
(
    calc_alu_if.slave bus
);

    logic [WIDTH:0] sum_add;

    assign sum_add = {1'b0, bus.a} + {1'b0, bus.b};

    // Decode the opcode into a result value, carry, compare and write enables.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        bus.result     = bus.a;
        bus.carry      = 1'b0;
        bus.cmp        = 1'b0;
        bus.writes_acc = 1'b0;
        bus.writes_cmp = 1'b0;
        case (bus.op)
            OP_ADD: begin
                bus.result     = sum_add[WIDTH-1:0];
                bus.carry      = sum_add[WIDTH];
                bus.writes_acc = 1'b1;
            end
            OP_SUB: begin
                bus.result     = bus.a - bus.b;
                bus.carry      = (bus.a < bus.b);
                bus.writes_acc = 1'b1;
            end
            OP_OR: begin
                bus.result     = bus.a | bus.b;
                bus.writes_acc = 1'b1;
            end
            OP_AND: begin
                bus.result     = bus.a & bus.b;
                bus.writes_acc = 1'b1;
            end
            OP_XOR: begin
                bus.result     = bus.a ^ bus.b;
                bus.writes_acc = 1'b1;
            end
            OP_SHL: begin
                bus.result     = {bus.a[WIDTH-2:0], 1'b0};
                bus.carry      = bus.a[WIDTH-1];
                bus.writes_acc = 1'b1;
            end
            OP_SHR: begin
                bus.result     = {1'b0, bus.a[WIDTH-1:1]};
                bus.carry      = bus.a[0];
                bus.writes_acc = 1'b1;
            end
            OP_SAR: begin
                bus.result     = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]};
                bus.carry      = bus.a[0];
                bus.writes_acc = 1'b1;
            end
            OP_NEG: begin
                bus.result     = '0 - bus.a;
                bus.writes_acc = 1'b1;
            end
            OP_INV: begin
                bus.result     = ~bus.a;
                bus.writes_acc = 1'b1;
            end
            OP_REV: begin
                for (int i = 0; i < WIDTH; i++) begin
                    bus.result[i] = bus.a[WIDTH-1-i];
                end
                bus.writes_acc = 1'b1;
            end
`ifdef CALC_ROTATE_EN
            OP_ROL: begin
                bus.result     = {bus.a[WIDTH-2:0], bus.a[WIDTH-1]};
                bus.carry      = bus.a[WIDTH-1];
                bus.writes_acc = 1'b1;
            end
            OP_ROR: begin
                bus.result     = {bus.a[0], bus.a[WIDTH-1:1]};
                bus.carry      = bus.a[0];
                bus.writes_acc = 1'b1;
            end
`endif
            OP_LT: begin
                bus.cmp        = ($signed(bus.a) < $signed(bus.b));
                bus.writes_cmp = 1'b1;
            end
            OP_GT: begin
                bus.cmp        = ($signed(bus.a) > $signed(bus.b));
                bus.writes_cmp = 1'b1;
            end
            OP_EQ: begin
                bus.cmp        = (bus.a == bus.b);
                bus.writes_cmp = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.zero = (bus.result == '0);

endmodule

// File: rtl/calculator_chip.sv
// 8-bit accumulator calculator tile. Operand on ui_in, opcode on uio_in[4:1],
// a rising edge on uio_in[0] executes one operation. Accumulator on uo_out,
// flags C/Z/T on uio_out[7:5].
// Optional feature: define CALC_ROTATE_EN to turn opcodes B/C into ROL/ROR.
module calculator_chip
    import calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic             t_q, t_d;
    logic             strobe_q, strobe_d;
    // Set once the strobe has been seen low after reset, so a strobe that is
    // already high when reset releases cannot fire an operation.
    logic             armed_q, armed_d;
    logic             exec;
    logic             unused_uio;

    calc_alu_if alu_bus ();

    assign alu_bus.a  = acc_q;
    assign alu_bus.b  = ui_in;
    assign alu_bus.op = calc_op_e'(uio_in[4:1]);

    calc_alu u_alu (
        .bus (alu_bus.slave)
    );

    assign exec       = uio_in[0] & ~strobe_q & armed_q & ena;
    assign unused_uio = &{1'b0, uio_in[7:5]};

    // Next-state: track the strobe, and on an execute load result and flags.
    always_comb begin
        strobe_d = uio_in[0];
        armed_d  = armed_q | ~uio_in[0];
        acc_d    = acc_q;
        c_d      = c_q;
        z_d      = z_q;
        t_d      = t_q;
        if (exec) begin
            if (alu_bus.writes_acc) begin
                acc_d = alu_bus.result;
                c_d   = alu_bus.carry;
                z_d   = alu_bus.zero;
                t_d   = 1'b0;
            end
            if (alu_bus.writes_cmp) begin
                t_d = alu_bus.cmp;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            acc_q    <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            t_q      <= 1'b0;
            strobe_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            c_q      <= c_d;
            z_q      <= z_d;
            t_q      <= t_d;
            strobe_q <= strobe_d;
            armed_q  <= armed_d;
        end
    end

    // Pad mapping of the flags; lower bidirectional bits are inputs.
    always_comb begin
        uio_out         = '0;
        uio_out[FLAG_C] = c_q;
        uio_out[FLAG_Z] = z_q;
        uio_out[FLAG_T] = t_q;
    end

    assign uo_out = acc_q;
    assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_calculator_chip.sv
// Directed self-checking bench for calculator_chip. Inputs change and outputs
// are sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_calculator_chip;
    import calc_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp = 0;
    int n_err = 0;

    calculator_chip dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%02h required 0x%02h", tag, obs, exp);
        end
    endtask

    // Raise the strobe with op/operand for 'hold' cycles, drop it for one,
    // then return on a falling edge ready for sampling.
    task automatic do_op(input calc_op_e op, input logic [7:0] b, input int hold);
        @(negedge clk);
        ui_in  = b;
        uio_in = {3'b000, op, 1'b1};
        repeat (hold) @(negedge clk);
        uio_in[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic [7:0] a_exp, input logic [7:0] f_exp);
        check({tag, ".A"}, uo_out, a_exp);
        check({tag, ".flags"}, uio_out, f_exp);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #12;
        check("reset.A", uo_out, 8'h00);
        check("reset.flags", uio_out, 8'h00);
        check("reset.oe", uio_oe, 8'hE0);
        @(negedge clk);
        rst_n = 1'b1;

        // Held strobe executes once.
        do_op(OP_ADD, 8'h01, 5);
        check_state("add_hold", 8'h01, 8'h00);
        do_op(OP_SUB, 8'h0F, 1);  check_state("sub", 8'hF2, 8'h80);
        do_op(OP_OR,  8'h01, 1);  check_state("or",  8'hF3, 8'h00);
        do_op(OP_AND, 8'h00, 1);  check_state("and", 8'h00, 8'h40);
        do_op(OP_XOR, 8'h55, 1);  check_state("xor", 8'h55, 8'h00);
        do_op(OP_SHL, 8'h00, 1);  check_state("shl", 8'hAA, 8'h00);
        do_op(OP_SHR, 8'h00, 1);  check_state("shr", 8'h55, 8'h00);
        do_op(OP_SAR, 8'h00, 1);  check_state("sar", 8'h2A, 8'h80);
        do_op(OP_NEG, 8'h00, 1);  check_state("neg", 8'hD6, 8'h00);
        do_op(OP_INV, 8'h00, 1);  check_state("inv", 8'h29, 8'h00);
        do_op(OP_REV, 8'h00, 1);  check_state("rev", 8'h94, 8'h00);

        // Signed compares, A = 0x94 (-108).
        do_op(OP_LT, 8'h7F, 1);   check_state("lt_7f", 8'h94, 8'h20);
        do_op(OP_LT, 8'hFF, 1);   check_state("lt_ff", 8'h94, 8'h20);
        do_op(OP_GT, 8'hFF, 1);   check_state("gt_ff", 8'h94, 8'h00);
        do_op(OP_GT, 8'h7F, 1);   check_state("gt_7f", 8'h94, 8'h00);
        do_op(OP_EQ, 8'h00, 1);   check_state("eq_00", 8'h94, 8'h00);
        do_op(OP_EQ, 8'h94, 1);   check_state("eq_94", 8'h94, 8'h20);

        // Tile disabled: strobe ignored, state held.
        ena = 1'b0;
        do_op(OP_ADD, 8'h01, 1);  check_state("ena_low", 8'h94, 8'h20);
        ena = 1'b1;

        // Build A = 0x81, then set T so the rotate step shows T handling.
        do_op(OP_AND, 8'h00, 1);  check_state("and_clr", 8'h00, 8'h40);
        do_op(OP_OR,  8'h81, 1);  check_state("or_81",   8'h81, 8'h00);
        do_op(OP_LT,  8'h7F, 1);  check_state("lt_81",   8'h81, 8'h20);
`ifdef CALC_ROTATE_EN
        do_op(OP_ROL, 8'h00, 1);  check_state("rol", 8'h03, 8'h80);
        do_op(OP_ROR, 8'h00, 1);  check_state("ror", 8'h81, 8'h80);
`else
        do_op(OP_ROL, 8'h00, 1);  check_state("nop_b", 8'h81, 8'h20);
        do_op(OP_ROR, 8'h00, 1);  check_state("nop_c", 8'h81, 8'h20);
`endif
        // Carry out of ADD: 0x81 + 0x80 = 0x101.
        do_op(OP_ADD, 8'h80, 1);  check_state("add_carry", 8'h01, 8'h80);

        // Async reset in the middle of a held strobe.
        @(negedge clk);
        ui_in  = 8'h10;
        uio_in = {3'b000, OP_ADD, 1'b1};
        @(negedge clk);
        check("pre_rst.A", uo_out, 8'h11);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst.A", uo_out, 8'h00);
        check("mid_rst.flags", uio_out, 8'h00);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_held.A", uo_out, 8'h00);
        check("post_rst_held.flags", uio_out, 8'h00);
        uio_in[0] = 1'b0;
        @(negedge clk);
        check("post_rst_low.A", uo_out, 8'h00);
        do_op(OP_ADD, 8'h05, 1);  check_state("post_rst_add", 8'h05, 8'h00);
        check("final.oe", uio_oe, 8'hE0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
